riot_io_timer: RTL and testbench

RIOT_IO_TIMER -- requirements
Module: riot_io_timer

---
 rtl/riot_pkg.sv | 42 ++++
 rtl/riot_io_timer_if.sv | 12 +
 rtl/riot_interval_timer.sv | 47 ++++
 rtl/riot_io_timer.sv | 120 ++++++++++++
 tb/tb_riot_io_timer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/riot_pkg.sv
// Shared types and constants for the RIOT-style I/O + interval timer block.
package riot_pkg;

    typedef enum logic [1:0] {
        PS_1    = 2'd0,
        PS_8    = 2'd1,
        PS_64   = 2'd2,
        PS_1024 = 2'd3
    } prescale_e;

    // Address field positions
    localparam int A_TSPACE   = 4;  // 1 = timer/interrupt space
    localparam int A_PORT_HI  = 3;  // must be 0 for a port access
    localparam int A_TWRITE   = 2;  // timer space: 1 = timer load on write
    localparam int A_TIE      = 3;  // timer load: interrupt enable
    localparam int A_DDR      = 0;  // port space: 1 = DDR, 0 = data
    localparam int A_STATUS   = 0;  // timer read: 1 = status, 0 = count
    localparam int A_EDGE_POL = 0;  // edge control write: 1 = rising
    localparam int A_EDGE_IE  = 1;  // edge control write: interrupt enable

    // Status byte flag positions
    localparam int FLAG_TIMER = 7;
    localparam int FLAG_EDGE  = 6;

    typedef struct packed {
        logic      load;
        logic [7:0] val;
        prescale_e ps;
        logic      rd_clr;
    } tmr_req_t;

    // Terminal prescaler count (P-1) for a prescale setting
    function automatic logic [9:0] ps_last(prescale_e ps);
        case (ps)
            PS_1:    return 10'd0;
            PS_8:    return 10'd7;
            PS_64:   return 10'd63;
            default: return 10'd1023;
        endcase
    endfunction

endpackage

// File: rtl/riot_io_timer_if.sv
// Register bus between a host and the RIOT I/O timer.
interface riot_io_timer_if;
    logic       cs;
    logic       we_n;
    logic [4:0] A;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       OE;

    modport master (output cs, we_n, A, DI, input DO, OE);
    modport slave  (input cs, we_n, A, DI, output DO, OE);
endinterface

// File: rtl/riot_interval_timer.sv
// 8-bit interval timer: prescaled down-count, wraps into /1 fast mode and raises its flag.
module riot_interval_timer
    import riot_pkg::*;
(
    input  logic       phi2,
    input  logic       rst_n,
    input  tmr_req_t   req,
    output logic [7:0] count,
    output logic       flag
);

    logic [9:0] pcnt;
    prescale_e  ps;
    logic       fast;
    logic       tick;
    logic       wrap;

    assign tick = fast | (pcnt == ps_last(ps));
    assign wrap = tick & (count == 8'h00);

    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            count <= 8'hFF;
            ps    <= PS_1024;
            pcnt  <= '0;
            fast  <= 1'b0;
            flag  <= 1'b0;
        end else if (req.load) begin
            count <= req.val;
            ps    <= req.ps;
            pcnt  <= '0;
            fast  <= 1'b0;
            flag  <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 10'd1;
            if (tick) count <= count - 8'd1;
            // A wrap landing on a count read keeps the flag set
            if (wrap) begin
                fast <= 1'b1;
                flag <= 1'b1;
            end else if (req.rd_clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/riot_io_timer.sv
// RIOT-style I/O block: NPORTS 8-bit ports with DDRs, an edge detector on port 0 and an interval timer.
module riot_io_timer
    import riot_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int EDGE_BIT = 7
)(
    input  logic                phi2,
    input  logic                rst_n,
    riot_io_timer_if.slave      bus,
    input  logic [NPORTS*8-1:0] PI,
    output logic [NPORTS*8-1:0] PO,
    output logic [NPORTS*8-1:0] DDR,
    output logic                irq_n
);

    logic                   rd, wr, tspace, port_ok;
    logic [1:0]             pn;
    logic [NPORTS-1:0][7:0] po_q, ddr_q, pi_w, port_rd;

    assign rd      = bus.cs & bus.we_n;
    assign wr      = bus.cs & ~bus.we_n;
    assign tspace  = bus.A[A_TSPACE];
    assign pn      = bus.A[2:1];
    assign port_ok = ~tspace & ~bus.A[A_PORT_HI] & (int'(pn) < NPORTS);

    assign pi_w = PI;
    assign PO   = po_q;
    assign DDR  = ddr_q;

    generate
        for (genvar g = 0; g < NPORTS; g++) begin : g_port
            assign port_rd[g] = (po_q[g] & ddr_q[g]) | (pi_w[g] & ~ddr_q[g]);
        end
    endgenerate

    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            po_q  <= '0;
            ddr_q <= '0;
        end else if (wr && port_ok) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (int'(pn) == i) begin
                    if (bus.A[A_DDR]) ddr_q[i] <= bus.DI;
                    else              po_q[i]  <= bus.DI;
                end
            end
        end
    end

    // Timer space reads decode only A[0]; the other address bits are don't-care there
    logic     rd_cnt, rd_stat, t_flag, t_ie;
    logic [7:0] t_count;
    tmr_req_t t_req;

    assign rd_cnt  = rd & tspace & ~bus.A[A_STATUS];
    assign rd_stat = rd & tspace & bus.A[A_STATUS];

    assign t_req.load   = wr & tspace & bus.A[A_TWRITE];
    assign t_req.val    = bus.DI;
    assign t_req.ps     = prescale_e'(bus.A[1:0]);
    assign t_req.rd_clr = rd_cnt;

    riot_interval_timer u_timer (
        .phi2  (phi2),
        .rst_n (rst_n),
        .req   (t_req),
        .count (t_count),
        .flag  (t_flag)
    );

    logic e_cur, e_q, e_hit, e_pol, e_ie, e_flag;

    assign e_cur = PI[EDGE_BIT];
    assign e_hit = e_pol ? (~e_q & e_cur) : (e_q & ~e_cur);

    always_ff @(posedge phi2) begin
        e_q <= e_cur;
        if (!rst_n) begin
            t_ie   <= 1'b0;
            e_pol  <= 1'b0;
            e_ie   <= 1'b0;
            e_flag <= 1'b0;
        end else begin
            if (t_req.load) t_ie <= bus.A[A_TIE];
            if (wr && tspace && !bus.A[A_TWRITE]) begin
                e_pol <= bus.A[A_EDGE_POL];
                e_ie  <= bus.A[A_EDGE_IE];
            end
            if (e_hit)        e_flag <= 1'b1;
            else if (rd_stat) e_flag <= 1'b0;
        end
    end

    logic [7:0] status;

    always_comb begin
        status             = '0;
        status[FLAG_TIMER] = t_flag;
        status[FLAG_EDGE]  = e_flag;
    end

    always_comb begin
        bus.DO = '0;
        bus.OE = 1'b0;
        if (rd) begin
            if (tspace) begin
                bus.OE = 1'b1;
                bus.DO = bus.A[A_STATUS] ? status : t_count;
            end else if (port_ok) begin
                bus.OE = 1'b1;
                for (int i = 0; i < NPORTS; i++)
                    if (int'(pn) == i) bus.DO = bus.A[A_DDR] ? ddr_q[i] : port_rd[i];
            end
        end
    end

    assign irq_n = ~((t_flag & t_ie) | (e_flag & e_ie));

endmodule

// File: tb/tb_riot_io_timer.sv
// Directed and randomized bench for riot_io_timer against an elapsed-time reference model.
module tb_riot_io_timer;
    localparam int NPORTS   = 2;
    localparam int EDGE_BIT = 7;

    logic                phi2 = 1'b0;
    logic                rst_n;
    logic [NPORTS*8-1:0] PI, PO, DDR;
    logic                irq_n;

    riot_io_timer_if bus ();

    riot_io_timer #(.NPORTS(NPORTS), .EDGE_BIT(EDGE_BIT)) dut (
        .phi2  (phi2),
        .rst_n (rst_n),
        .bus   (bus),
        .PI    (PI),
        .PO    (PO),
        .DDR   (DDR),
        .irq_n (irq_n)
    );

    always #5 phi2 = ~phi2;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    // Reference model: timer is described by load value, divider and load time only
    logic [7:0] m_po [NPORTS];
    logic [7:0] m_ddr[NPORTS];
    int m_lv, m_p, m_lc;
    bit m_tflag, m_tie, m_eflag, m_eie, m_pol, m_eprev;

    logic [7:0] obs_do;
    logic       obs_oe, obs_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int ps_div(logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 8;
            2'd2:    return 64;
            default: return 1024;
        endcase
    endfunction

    // Count after e edges since load: (lv+1)*P edges reach the wrap, then one step per edge
    function automatic logic [7:0] m_count();
        int e  = cyc - m_lc;
        int tw = (m_lv + 1) * m_p;
        if (e < tw) return 8'(m_lv - e / m_p);
        return 8'(255 - ((e - tw) % 256));
    endfunction

    function automatic bit m_wrap(int e);
        int tw = (m_lv + 1) * m_p;
        return (e >= tw) && (((e - tw) % 256) == 0);
    endfunction

    function automatic bit m_irq();
        return !((m_tflag && m_tie) || (m_eflag && m_eie));
    endfunction

    task automatic exp_out(output logic [7:0] d, output logic oe);
        int n = int'(bus.A[2:1]);
        logic [7:0] pin;
        d  = 8'h00;
        oe = 1'b0;
        if (bus.cs && bus.we_n) begin
            if (bus.A[4]) begin
                oe = 1'b1;
                d  = bus.A[0] ? {m_tflag, m_eflag, 6'b0} : m_count();
            end else if (!bus.A[3] && n < NPORTS) begin
                pin = PI[8*n +: 8];
                oe  = 1'b1;
                d   = bus.A[0] ? m_ddr[n] : ((m_po[n] & m_ddr[n]) | (pin & ~m_ddr[n]));
            end
        end
    endtask

    task automatic model_update();
        bit cur = PI[EDGE_BIT];
        int n   = int'(bus.A[2:1]);
        bit rd  = bus.cs && bus.we_n;
        bit wr  = bus.cs && !bus.we_n;
        bit det;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NPORTS; i++) begin m_po[i] = 8'h00; m_ddr[i] = 8'h00; end
            m_lv = 255; m_p = 1024; m_lc = cyc;
            m_tflag = 0; m_tie = 0; m_eflag = 0; m_eie = 0; m_pol = 0;
            m_eprev = cur;
            return;
        end
        det = m_pol ? (!m_eprev && cur) : (m_eprev && !cur);
        if (wr && bus.A[4] && bus.A[2]) begin
            m_lv = int'(bus.DI); m_p = ps_div(bus.A[1:0]); m_lc = cyc;
            m_tflag = 0; m_tie = bus.A[3];
        end else if (m_wrap(cyc - m_lc)) m_tflag = 1;
        else if (rd && bus.A[4] && !bus.A[0]) m_tflag = 0;
        if (det) m_eflag = 1;
        else if (rd && bus.A[4] && bus.A[0]) m_eflag = 0;
        if (wr && bus.A[4] && !bus.A[2]) begin m_pol = bus.A[0]; m_eie = bus.A[1]; end
        if (wr && !bus.A[4] && !bus.A[3] && n < NPORTS) begin
            if (bus.A[0]) m_ddr[n] = bus.DI;
            else          m_po[n]  = bus.DI;
        end
        m_eprev = cur;
    endtask

    // One bus cycle: drive, check outputs mid-cycle, advance model at the edge
    task automatic step(input bit r, input bit c, input bit w, input logic [4:0] a, input logic [7:0] d);
        logic [7:0] ed;
        logic       eo;
        rst_n = r; bus.cs = c; bus.we_n = w; bus.A = a; bus.DI = d;
        @(negedge phi2);
        obs_do = bus.DO; obs_oe = bus.OE; obs_irq = irq_n;
        exp_out(ed, eo);
        chk("oe", 32'(obs_oe), 32'(eo));
        chk("do", 32'(obs_do), 32'(ed));
        chk("irq_n", 32'(obs_irq), 32'(m_irq()));
        for (int i = 0; i < NPORTS; i++) begin
            chk("po", 32'(PO[8*i +: 8]), 32'(m_po[i]));
            chk("ddr", 32'(DDR[8*i +: 8]), 32'(m_ddr[i]));
        end
        @(posedge phi2);
        model_update();
        #1;
    endtask

    task automatic idle();                                  step(1, 0, 1, 5'h00, 8'h00); endtask
    task automatic rd(input logic [4:0] a);                 step(1, 1, 1, a, 8'h00);     endtask
    task automatic wr(input logic [4:0] a, input logic [7:0] d); step(1, 1, 0, a, d);   endtask

    initial begin
        int lc;
        bus.cs = 1'b0; bus.we_n = 1'b1; bus.A = '0; bus.DI = '0;
        PI = 16'h003C; rst_n = 1'b0;
        @(posedge phi2);
        model_update();
        #1;

        // Reset state
        rd(5'h10); chk("rst_cnt", 32'(obs_do), 32'h00FF); chk("rst_irq", 32'(obs_irq), 32'd1);
        rd(5'h11); chk("rst_stat", 32'(obs_do), 32'h0000);
        chk("rst_po", 32'(PO), 32'h0); chk("rst_ddr", 32'(DDR), 32'h0);

        // Port data mix and out-of-range ports
        wr(5'h01, 8'hF0); wr(5'h00, 8'hA5);
        rd(5'h00); chk("port_mix", 32'(obs_do), 32'h00AC);
        rd(5'h01); chk("ddr_rd", 32'(obs_do), 32'h00F0);
        rd(5'h04); chk("bad_port_oe", 32'(obs_oe), 32'd0); chk("bad_port_do", 32'(obs_do), 32'd0);
        rd(5'h08); chk("a3_port_oe", 32'(obs_oe), 32'd0);
        wr(5'h09, 8'h11); chk("a3_no_wr", 32'(PO), 32'h00A5);

        // /1024 load with IE (A[3]=1), wrap, fast mode, read-clear, set-wins
        wr(5'h1F, 8'h03); lc = cyc;
        while (cyc < lc + 1024) idle();
        rd(5'h10); chk("cnt_1024", 32'(obs_do), 32'h02);
        while (cyc < lc + 4096) idle();
        rd(5'h10); chk("cnt_wrap", 32'(obs_do), 32'hFF); chk("irq_wrap", 32'(obs_irq), 32'd0);
        rd(5'h10); chk("cnt_fast", 32'(obs_do), 32'hFE); chk("irq_clr", 32'(obs_irq), 32'd1);
        while (cyc < lc + 4351) idle();
        rd(5'h10); chk("cnt_zero", 32'(obs_do), 32'h00);
        rd(5'h11); chk("set_wins", 32'(obs_do), 32'h80); chk("irq_set_wins", 32'(obs_irq), 32'd0);

        // Rising edge with IE
        wr(5'h17, 8'hFF);
        rd(5'h11); chk("stat_clr", 32'(obs_do), 32'h00);
        wr(5'h13, 8'h5A);
        PI = 16'h00BC; idle();
        rd(5'h11); chk("edge_stat", 32'(obs_do), 32'h40); chk("edge_irq", 32'(obs_irq), 32'd0);
        rd(5'h11); chk("edge_stat2", 32'(obs_do), 32'h00); chk("edge_irq2", 32'(obs_irq), 32'd1);

        // Reset mid-count with a concurrent timer write
        wr(5'h01, 8'hFF); wr(5'h1F, 8'h40); idle(); idle();
        step(0, 1, 0, 5'h1F, 8'h55);
        rd(5'h10); chk("rst2_cnt", 32'(obs_do), 32'hFF); chk("rst2_irq", 32'(obs_irq), 32'd1);
        chk("rst2_po", 32'(PO), 32'h0); chk("rst2_ddr", 32'(DDR), 32'h0);
        PI = 16'h003C; idle();
        rd(5'h11); chk("rst2_fall", 32'(obs_do), 32'h40); chk("rst2_noie", 32'(obs_irq), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) PI = 16'($urandom);
            if ($urandom_range(0, 399) == 0)
                step(0, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
            else if ($urandom_range(0, 9) < 4)
                idle();
            else if ($urandom_range(0, 3) == 0)
                // short loads on a fast divider so wraps happen often
                wr({3'b101, 2'($urandom_range(0, 2))} | {1'b0, 1'($urandom), 3'b000}, 8'($urandom_range(0, 40)));
            else
                step(1, 1, 1'($urandom), 5'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
